// File: rtl/lcd_sched_pkg.sv
// -----------------------------------------------------------------------------
// lcd_sched_pkg
// Shared definitions for the LCD record scheduler:
//   - FSM state encoding (plain localparams so older tools and netlists that
//     expect a fixed 3-bit encoding keep working)
//   - default record width (flat BCD timestamp, 4 units x 2 digits x 4 bits)
//   - width of the lcd_busy acknowledge timeout counter
// -----------------------------------------------------------------------------
package lcd_sched_pkg;

  localparam int DEFAULT_REC_W = 32;

  // Wide enough for any ACK_TIMEOUT up to 256 cycles.
  localparam int ACK_CNT_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE_INS = 3'd1;
  localparam logic [2:0] ST_ISSUE_CLR = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

endpackage

// File: rtl/record_fifo.sv
// -----------------------------------------------------------------------------
// record_fifo
// Small synchronous FIFO holding lap records waiting for the LCD.
//   clock, reset : system clock, synchronous active-high reset
//   wr_en/wr_data: push a record (accepted when not full, or when a read
//                  happens in the same cycle)
//   rd_en        : pop the head; rd_data always shows the current head
//   flush        : drop every queued entry (wins over read and write)
//   count        : number of queued entries, full/empty flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module record_fifo #(
  parameter int REC_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [REC_W-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic                     flush,
  output logic [REC_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A read frees a slot at the same edge, so a write on full is still safe.
  assign do_rd = rd_en && !empty && !flush;
  assign do_wr = wr_en && (!full || do_rd) && !flush;

  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count decide
  // which entries are valid, so resetting the data would only cost logic.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_record_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_record_scheduler
// Sits between key_logic_fsm and lcd_bridge. Lap records are queued in a
// small FIFO and handed to lcd_bridge one at a time using its busy flag;
// clear requests flush the queue and are issued ahead of any queued insert.
//   clock, reset : system clock, synchronous active-high reset
//   insert_req   : one-cycle pulse, enqueue record_in
//   clear_req    : one-cycle pulse, flush queue and clear the LCD
//   record_in    : record captured on insert_req
//   lcd_busy     : busy flag from lcd_bridge
//   lcd_insert   : one-cycle registered insert pulse to lcd_bridge
//   lcd_clear    : one-cycle registered clear pulse to lcd_bridge
//   lcd_record   : record for lcd_bridge, loaded only on dequeue
//   pending      : queued entries, excluding the one in flight
//   full         : pending == DEPTH
//   busy         : anything in flight, queued, or a clear waiting
//   overflow     : sticky, an insert was dropped (cleared by clear_req)
//   ack_err      : sticky, lcd_busy never rose after an issue pulse
// -----------------------------------------------------------------------------
module lcd_record_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int REC_W       = DEFAULT_REC_W,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     insert_req,
  input  logic                     clear_req,
  input  logic [REC_W-1:0]         record_in,
  input  logic                     lcd_busy,
  output logic                     lcd_insert,
  output logic                     lcd_clear,
  output logic [REC_W-1:0]         lcd_record,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     full,
  output logic                     busy,
  output logic                     overflow,
  output logic                     ack_err
);

  logic [2:0]           state;
  logic                 clear_pend;
  logic [ACK_CNT_W-1:0] ack_cnt;

  logic [REC_W-1:0]     head;
  logic                 fifo_empty;
  logic                 clr_take;
  logic                 wr_req;
  logic                 deq;
  logic                 timeout;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    clr_take = 1'b0;
    wr_req   = 1'b0;
    deq      = 1'b0;
    timeout  = 1'b0;

    // A clear already waiting absorbs a repeat; the exception is the cycle
    // the pending clear is being issued, where a new one must be kept.
    clr_take = clear_req && (!clear_pend || (state == ST_ISSUE_CLR));

    // An insert coinciding with a clear would be flushed anyway: drop it
    // without flagging overflow.
    wr_req = insert_req && !clear_req;

    deq = (state == ST_IDLE) && !clear_pend && !clr_take &&
          !lcd_busy && !fifo_empty;

    // ack_cnt counts cycles already spent in WAIT_ACK, so the last one
    // expires when it reads ACK_TIMEOUT-1.
    timeout = (state == ST_WAIT_ACK) && !lcd_busy &&
              (ack_cnt == ACK_CNT_W'(ACK_TIMEOUT - 1));
  end

  record_fifo #(
    .REC_W (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_req),
    .wr_data (record_in),
    .rd_en   (deq),
    .flush   (clr_take),
    .rd_data (head),
    .count   (pending),
    .full    (full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      clear_pend <= 1'b0;
      ack_cnt    <= '0;
      lcd_insert <= 1'b0;
      lcd_clear  <= 1'b0;
      lcd_record <= '0;
      overflow   <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      // Issue pulses are registered and default low, so each lasts exactly
      // the one cycle spent in its ISSUE state.
      lcd_insert <= 1'b0;
      lcd_clear  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (clear_pend && !lcd_busy) begin
            state     <= ST_ISSUE_CLR;
            lcd_clear <= 1'b1;
          end else if (deq) begin
            state      <= ST_ISSUE_INS;
            lcd_insert <= 1'b1;
            lcd_record <= head;
          end
        end
        ST_ISSUE_INS,
        ST_ISSUE_CLR: begin
          state   <= ST_WAIT_ACK;
          ack_cnt <= '0;
        end
        ST_WAIT_ACK: begin
          if (lcd_busy)     state   <= ST_WAIT_DONE;
          else if (timeout) state   <= ST_IDLE;
          else              ack_cnt <= ack_cnt + ACK_CNT_W'(1);
        end
        ST_WAIT_DONE: begin
          if (!lcd_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (clr_take)                   clear_pend <= 1'b1;
      else if (state == ST_ISSUE_CLR) clear_pend <= 1'b0;

      // Clear wipes the sticky flags; a new fault in the same cycle wins.
      if (clr_take) begin
        overflow <= 1'b0;
        ack_err  <= 1'b0;
      end
      if (wr_req && full && !deq) overflow <= 1'b1;
      if (timeout)                ack_err  <= 1'b1;
    end
  end

  assign busy = (state != ST_IDLE) || (pending != '0) || clear_pend;

endmodule

// File: tb/tb_lcd_record_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lcd_record_scheduler
// Self-checking bench for lcd_record_scheduler with a behavioural lcd_bridge
// model (raises lcd_busy for model_len cycles after each issue pulse) and a
// scoreboard of records expected on lcd_insert, in issue order.
// -----------------------------------------------------------------------------
module tb_lcd_record_scheduler;

  localparam int DEPTH = 4;
  localparam int REC_W = 32;
  localparam int ACK_TIMEOUT = 15;

  logic             clock = 1'b0;
  logic             reset;
  logic             insert_req;
  logic             clear_req;
  logic [REC_W-1:0] record_in;
  logic             lcd_busy = 1'b0;
  logic             lcd_insert;
  logic             lcd_clear;
  logic [REC_W-1:0] lcd_record;
  logic [2:0]       pending;
  logic             full;
  logic             busy;
  logic             overflow;
  logic             ack_err;

  lcd_record_scheduler #(
    .DEPTH       (DEPTH),
    .REC_W       (REC_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .insert_req (insert_req),
    .clear_req  (clear_req),
    .record_in  (record_in),
    .lcd_busy   (lcd_busy),
    .lcd_insert (lcd_insert),
    .lcd_clear  (lcd_clear),
    .lcd_record (lcd_record),
    .pending    (pending),
    .full       (full),
    .busy       (busy),
    .overflow   (overflow),
    .ack_err    (ack_err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- lcd_bridge model ----------------
  int model_len = 8;
  bit model_respond = 1'b1;
  int busy_cnt = 0;

  always @(negedge clock) begin
    if (reset) begin
      busy_cnt = 0;
      lcd_busy = 1'b0;
    end else if ((lcd_insert || lcd_clear) && model_respond) begin
      busy_cnt = model_len;
      lcd_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) lcd_busy = 1'b0;
    end
  end

  // ---------------- scoreboard / pulse monitor ----------------
  logic [REC_W-1:0] exp_q[$];
  int n_ins = 0;
  int n_clr = 0;
  int cyc = 0;
  int last_pulse_cyc = -1;
  int min_gap = 4;
  bit prev_pulse = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (lcd_insert || lcd_clear) begin
        check("pulse_exclusive", 32'(lcd_insert & lcd_clear), 32'd0);
        check("pulse_single_cycle", 32'(prev_pulse), 32'd0);
        if (last_pulse_cyc >= 0)
          check("pulse_gap", 32'((cyc - last_pulse_cyc) >= min_gap), 32'd1);
        last_pulse_cyc = cyc;
        if (lcd_insert) begin
          n_ins++;
          if (exp_q.size() == 0) check("unexpected_insert", lcd_record, 32'hxxxx_xxxx);
          else                   check("lcd_record_order", lcd_record, exp_q.pop_front());
        end
        if (lcd_clear) n_clr++;
      end
      prev_pulse = lcd_insert | lcd_clear;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic drive(input logic ins, input logic clr, input logic [REC_W-1:0] rec);
    @(negedge clock);
    insert_req = ins;
    clear_req  = clr;
    record_in  = rec;
    @(posedge clock);
    #1;
    insert_req = 1'b0;
    clear_req  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((busy || lcd_busy) && n < max_cyc) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("idle_reached", 32'(!(busy || lcd_busy)), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             ins;
    logic             clr;
    logic [REC_W-1:0] rec;
    int               busy_len;
    logic [2:0]       exp_pend_k;
    logic             exp_ins;
    logic             exp_clr;
    logic [REC_W-1:0] exp_rec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0_ins;
    int n0_clr;
    logic seen;

    vecs[0] = '{1'b1, 1'b0, 32'h0012_3456, 20, 3'd1, 1'b1, 1'b0, 32'h0012_3456};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0000,  6, 3'd1, 1'b1, 1'b0, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h9959_5999,  4, 3'd1, 1'b1, 1'b0, 32'h9959_5999};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_1111,  8, 3'd0, 1'b0, 1'b1, 32'h9959_5999};
    vecs[4] = '{1'b1, 1'b1, 32'hDEAD_BEEF,  8, 3'd0, 1'b0, 1'b1, 32'h9959_5999};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 12, 3'd1, 1'b1, 1'b0, 32'hFFFF_FFFF};

    reset      = 1'b1;
    insert_req = 1'b0;
    clear_req  = 1'b0;
    record_in  = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_flags", {26'd0, lcd_insert, lcd_clear, full, busy, overflow, ack_err}, 32'd0);
    check("reset_lcd_record", lcd_record, 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Table: isolated requests from idle (single lap, clear, simultaneous)
    for (int i = 0; i < 6; i++) begin
      model_len      = vecs[i].busy_len;
      min_gap        = vecs[i].busy_len;
      last_pulse_cyc = -1;
      n0_ins = n_ins;
      n0_clr = n_clr;
      if (vecs[i].exp_ins) exp_q.push_back(vecs[i].rec);
      drive(vecs[i].ins, vecs[i].clr, vecs[i].rec);
      check($sformatf("v%0d_pending_k", i), 32'(pending), 32'(vecs[i].exp_pend_k));
      check($sformatf("v%0d_busy_k", i), 32'(busy), 32'd1);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_lcd_insert", i), 32'(lcd_insert), 32'(vecs[i].exp_ins));
      check($sformatf("v%0d_lcd_clear", i), 32'(lcd_clear), 32'(vecs[i].exp_clr));
      check($sformatf("v%0d_lcd_record", i), lcd_record, vecs[i].exp_rec);
      check($sformatf("v%0d_pending_issue", i), 32'(pending), 32'd0);
      n = 0;
      seen = 1'b0;
      while (n < 200) begin
        @(posedge clock);
        #1;
        n++;
        if (lcd_busy) seen = 1'b1;
        else if (seen) break;
      end
      check($sformatf("v%0d_bridge_cycle", i), 32'(seen && !lcd_busy), 32'd1);
      check($sformatf("v%0d_busy_follows", i), 32'(busy), 32'd0);
      wait_idle(50);
      check($sformatf("v%0d_ins_count", i), 32'(n_ins - n0_ins), 32'(vecs[i].exp_ins));
      check($sformatf("v%0d_clr_count", i), 32'(n_clr - n0_clr), 32'(vecs[i].exp_clr));
      check($sformatf("v%0d_flags", i), {30'd0, overflow, ack_err}, 32'd0);
    end

    // Burst with overflow: 6 back-to-back inserts, 5 fit (one dequeued early)
    model_len      = 50;
    min_gap        = 50;
    last_pulse_cyc = -1;
    n0_ins = n_ins;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      insert_req = 1'b1;
      record_in  = 32'h0000_0100 + 32'(i);
      if (i <= 5) exp_q.push_back(32'h0000_0100 + 32'(i));
    end
    @(posedge clock);
    #1;
    insert_req = 1'b0;
    check("burst_overflow_set", 32'(overflow), 32'd1);
    check("burst_full", 32'(full), 32'd1);
    check("burst_pending", 32'(pending), 32'd4);
    wait_idle(1000);
    check("burst_insert_count", 32'(n_ins - n0_ins), 32'd5);
    check("burst_overflow_sticky", 32'(overflow), 32'd1);
    check("burst_queue_drained", 32'(exp_q.size()), 32'd0);
    drive(1'b0, 1'b1, '0);
    check("clear_resets_overflow", 32'(overflow), 32'd0);
    wait_idle(200);

    // Clear mid-stream: first record in flight, two queued and discarded
    model_len      = 30;
    min_gap        = 30;
    last_pulse_cyc = -1;
    n0_ins = n_ins;
    n0_clr = n_clr;
    exp_q.push_back(32'h0000_0201);
    drive(1'b1, 1'b0, 32'h0000_0201);
    drive(1'b1, 1'b0, 32'h0000_0202);
    drive(1'b1, 1'b0, 32'h0000_0203);
    check("mid_pending_before", 32'(pending), 32'd2);
    repeat (5) @(posedge clock);
    drive(1'b0, 1'b1, '0);
    check("mid_pending_flushed", 32'(pending), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    wait_idle(200);
    check("mid_ins_count", 32'(n_ins - n0_ins), 32'd1);
    check("mid_clr_count", 32'(n_clr - n0_clr), 32'd1);
    check("mid_flags", {29'd0, overflow, ack_err, |pending}, 32'd0);

    // Ack timeout: bridge never raises busy
    model_respond  = 1'b0;
    min_gap        = 4;
    last_pulse_cyc = -1;
    n0_ins = n_ins;
    exp_q.push_back(32'h0000_0301);
    exp_q.push_back(32'h0000_0302);
    drive(1'b1, 1'b0, 32'h0000_0301);
    drive(1'b1, 1'b0, 32'h0000_0302);
    repeat (15) @(posedge clock);
    #1;
    check("timeout_not_early", 32'(ack_err), 32'd0);
    @(posedge clock);
    #1;
    check("timeout_ack_err", 32'(ack_err), 32'd1);
    wait_idle(100);
    check("timeout_next_issued", 32'(n_ins - n0_ins), 32'd2);
    check("timeout_ack_err_sticky", 32'(ack_err), 32'd1);
    model_respond = 1'b1;
    model_len     = 8;
    drive(1'b0, 1'b1, '0);
    check("clear_resets_ack_err", 32'(ack_err), 32'd0);
    wait_idle(100);

    // Reset in WAIT_DONE with two records queued
    model_len      = 30;
    min_gap        = 4;
    last_pulse_cyc = -1;
    exp_q.push_back(32'h0000_0401);
    drive(1'b1, 1'b0, 32'h0000_0401);
    drive(1'b1, 1'b0, 32'h0000_0402);
    drive(1'b1, 1'b0, 32'h0000_0403);
    repeat (3) @(posedge clock);
    #1;
    check("rst_pending_before", 32'(pending), 32'd2);
    check("rst_bridge_busy", 32'(lcd_busy), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_flags", {26'd0, lcd_insert, lcd_clear, full, busy, overflow, ack_err}, 32'd0);
    check("rst_mid_lcd_record", lcd_record, 32'd0);
    check("rst_mid_pending", 32'(pending), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    n0_ins = n_ins;
    n0_clr = n_clr;
    repeat (10) @(posedge clock);
    #1;
    check("rst_no_pulses", 32'((n_ins - n0_ins) + (n_clr - n0_clr)), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
